// File: rtl/morse_encoder_pkg.sv
// Shared types and constants for the Morse encoder path: FSM states,
// LUT code payload, ASCII landmarks and unit counts per keying segment.
package morse_encoder_pkg;

  localparam int unsigned LEN_W = 3;
  localparam int unsigned PAT_W = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_ON,
    S_GAP,
    S_CHAR,
    S_WORD
  } state_e;

  // pat is left-aligned: pat[4] is the first element, 1 = dash
  typedef struct packed {
    logic             valid;
    logic [LEN_W-1:0] len;
    logic [PAT_W-1:0] pat;
  } morse_code_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_UA    = 8'h41;
  localparam logic [7:0] ASCII_LA    = 8'h61;
  localparam logic [7:0] ASCII_LZ    = 8'h7A;

  localparam logic [2:0] UNITS_DOT  = 3'd1;
  localparam logic [2:0] UNITS_DASH = 3'd3;
  localparam logic [2:0] UNITS_EGAP = 3'd1;
  localparam logic [2:0] UNITS_CGAP = 3'd3;
  localparam logic [2:0] UNITS_WGAP = 3'd4;

  function automatic logic [2:0] elem_units(input logic dash);
    return dash ? UNITS_DASH : UNITS_DOT;
  endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational ASCII -> Morse code lookup (ITU letters and digits),
// with lower-case folded onto upper-case.
module morse_lut
  import morse_encoder_pkg::*;
(
  input  logic [6:0]  ascii,
  output morse_code_t code_c
);

  logic [6:0] ch;

  always_comb begin
    ch = ascii;
    if (ascii >= ASCII_LA[6:0] && ascii <= ASCII_LZ[6:0]) begin
      ch = ascii - 7'(ASCII_LA - ASCII_UA);
    end
    code_c = '0;
    case (ch)
      7'h41: code_c = {1'b1, 3'd2, 5'b01000}; // A
      7'h42: code_c = {1'b1, 3'd4, 5'b10000};
      7'h43: code_c = {1'b1, 3'd4, 5'b10100};
      7'h44: code_c = {1'b1, 3'd3, 5'b10000};
      7'h45: code_c = {1'b1, 3'd1, 5'b00000};
      7'h46: code_c = {1'b1, 3'd4, 5'b00100};
      7'h47: code_c = {1'b1, 3'd3, 5'b11000};
      7'h48: code_c = {1'b1, 3'd4, 5'b00000};
      7'h49: code_c = {1'b1, 3'd2, 5'b00000};
      7'h4A: code_c = {1'b1, 3'd4, 5'b01110};
      7'h4B: code_c = {1'b1, 3'd3, 5'b10100};
      7'h4C: code_c = {1'b1, 3'd4, 5'b01000};
      7'h4D: code_c = {1'b1, 3'd2, 5'b11000};
      7'h4E: code_c = {1'b1, 3'd2, 5'b10000};
      7'h4F: code_c = {1'b1, 3'd3, 5'b11100};
      7'h50: code_c = {1'b1, 3'd4, 5'b01100};
      7'h51: code_c = {1'b1, 3'd4, 5'b11010};
      7'h52: code_c = {1'b1, 3'd3, 5'b01000};
      7'h53: code_c = {1'b1, 3'd3, 5'b00000};
      7'h54: code_c = {1'b1, 3'd1, 5'b10000};
      7'h55: code_c = {1'b1, 3'd3, 5'b00100};
      7'h56: code_c = {1'b1, 3'd4, 5'b00010};
      7'h57: code_c = {1'b1, 3'd3, 5'b01100};
      7'h58: code_c = {1'b1, 3'd4, 5'b10010};
      7'h59: code_c = {1'b1, 3'd4, 5'b10110};
      7'h5A: code_c = {1'b1, 3'd4, 5'b11000};
      7'h30: code_c = {1'b1, 3'd5, 5'b11111}; // 0
      7'h31: code_c = {1'b1, 3'd5, 5'b01111};
      7'h32: code_c = {1'b1, 3'd5, 5'b00111};
      7'h33: code_c = {1'b1, 3'd5, 5'b00011};
      7'h34: code_c = {1'b1, 3'd5, 5'b00001};
      7'h35: code_c = {1'b1, 3'd5, 5'b00000};
      7'h36: code_c = {1'b1, 3'd5, 5'b10000};
      7'h37: code_c = {1'b1, 3'd5, 5'b11000};
      7'h38: code_c = {1'b1, 3'd5, 5'b11100};
      7'h39: code_c = {1'b1, 3'd5, 5'b11110};
      default: code_c = '0;
    endcase
  end

endmodule

// File: rtl/morse_encoder.sv
// Pops ASCII characters from the FIFO and keys them out as Morse with
// unit timing; every output is a flop loaded from the next-state decode.
module morse_encoder
  import morse_encoder_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 4,
  parameter int unsigned DATA_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  key_out,
  output logic                  busy,
  output logic                  char_done,
  output logic                  bad_char
);

  localparam int unsigned CNT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(UNIT_CYCLES - 2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] unit_cnt_q, unit_cnt_d;
  logic [2:0]       units_q, units_d;
  logic [PAT_W-1:0] sreg_q, sreg_d;
  logic [LEN_W-1:0] elems_q, elems_d;
  logic             key_q, key_d;
  logic             pop_q, pop_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bad_q, bad_d;

  morse_code_t lut_code;
  logic        is_space, is_valid, unit_end, seg_end;

  morse_lut u_lut (
    .ascii  (fifo_data[6:0]),
    .code_c (lut_code)
  );

  assign is_space = (fifo_data == DATA_WIDTH'(ASCII_SPACE));
  assign is_valid = lut_code.valid && !(|fifo_data[DATA_WIDTH-1:7]);
  assign unit_end = (unit_cnt_q == CNT_LAST);
  assign seg_end  = unit_end && (units_q == 3'd1);

  // Next-state, counter and output decode
  always_comb begin
    state_d    = state_q;
    unit_cnt_d = unit_cnt_q;
    units_d    = units_q;
    sreg_d     = sreg_q;
    elems_d    = elems_q;
    bad_d      = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: if (enable && !fifo_empty) state_d = S_POP;
      S_POP:  state_d = S_LOAD;
      S_LOAD: begin
        unit_cnt_d = '0;
        if (is_valid) begin
          state_d = S_ON;
          sreg_d  = lut_code.pat;
          elems_d = lut_code.len;
          units_d = elem_units(lut_code.pat[PAT_W-1]);
        end else if (is_space) begin
          state_d = S_WORD;
          units_d = UNITS_WGAP;
        end else begin
          state_d = S_IDLE;
          bad_d   = 1'b1;
        end
      end
      S_ON, S_GAP, S_CHAR, S_WORD: begin
        unit_cnt_d = unit_end ? '0 : unit_cnt_q + CNT_W'(1);
        if (unit_end) units_d = units_q - 3'd1;
        // pulse lands on the last cycle of the trailing gap
        if ((state_q == S_CHAR || state_q == S_WORD) &&
            units_q == 3'd1 && unit_cnt_q == CNT_PRE) begin
          done_d = 1'b1;
        end
        if (seg_end) begin
          if (state_q == S_ON) begin
            if (elems_q == LEN_W'(1)) begin
              state_d = S_CHAR;
              units_d = UNITS_CGAP;
            end else begin
              state_d = S_GAP;
              units_d = UNITS_EGAP;
              sreg_d  = sreg_q << 1;
              elems_d = elems_q - LEN_W'(1);
            end
          end else if (state_q == S_GAP) begin
            state_d = S_ON;
            units_d = elem_units(sreg_q[PAT_W-1]);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    key_d  = (state_d == S_ON);
    pop_d  = (state_d == S_POP);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      unit_cnt_q <= '0;
      units_q    <= '0;
      sreg_q     <= '0;
      elems_q    <= '0;
      key_q      <= 1'b0;
      pop_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      unit_cnt_q <= unit_cnt_d;
      units_q    <= units_d;
      sreg_q     <= sreg_d;
      elems_q    <= elems_d;
      key_q      <= key_d;
      pop_q      <= pop_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bad_q      <= bad_d;
    end
  end

  assign key_out   = key_q;
  assign fifo_pop  = pop_q;
  assign busy      = busy_q;
  assign char_done = done_q;
  assign bad_char  = bad_q;

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder with a 1-cycle registered-read FIFO model;
// key edges and strobes are time-stamped on the falling clock edge.
module tb_morse_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       fifo_empty;
  logic       fifo_pop;
  logic [7:0] fifo_data = 8'h00;
  logic       key_out;
  logic       busy;
  logic       char_done;
  logic       bad_char;

  morse_encoder #(.UNIT_CYCLES(4), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_pop   (fifo_pop),
    .fifo_data  (fifo_data),
    .key_out    (key_out),
    .busy       (busy),
    .char_done  (char_done),
    .bad_char   (bad_char)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [32];
  logic [4:0] wr_ptr = 5'd0;
  logic [4:0] rd_ptr = 5'd0;
  logic       underflow = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_pop) begin
      if (fifo_empty) underflow <= 1'b1;
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 5'd1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int t        = 0;
  int rise_t [16];
  int fall_t [16];
  int cd_t   [16];
  int pop_t  [16];
  int bad_t  [16];
  int n_rise, n_fall, n_cd, n_pop, n_bad;
  logic last_key;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic push(input logic [7:0] ch);
    mem[wr_ptr] = ch;
    wr_ptr      = wr_ptr + 5'd1;
  endtask

  task automatic clear_log();
    n_rise = 0; n_fall = 0; n_cd = 0; n_pop = 0; n_bad = 0;
    last_key = key_out;
  endtask

  task automatic tick();
    @(negedge clk);
    t++;
    if (key_out && !last_key) begin if (n_rise < 16) rise_t[n_rise] = t; n_rise++; end
    if (!key_out && last_key) begin if (n_fall < 16) fall_t[n_fall] = t; n_fall++; end
    if (char_done) begin if (n_cd  < 16) cd_t[n_cd]   = t; n_cd++;  end
    if (fifo_pop)  begin if (n_pop < 16) pop_t[n_pop] = t; n_pop++; end
    if (bad_char)  begin if (n_bad < 16) bad_t[n_bad] = t; n_bad++; end
    last_key = key_out;
  endtask

  task automatic wait_rise(input string tag, input int budget);
    int start;
    start = n_rise;
    for (int i = 0; i < budget && n_rise == start; i++) tick();
    check({tag, "_rise_seen"}, int'(n_rise > start), 1);
  endtask

  // 'A' = dot, gap, dash, then the 3-unit character gap
  task automatic run_a(input logic [7:0] ch, input string nm);
    clear_log();
    push(ch);
    repeat (60) tick();
    check({nm, "_pops"},      n_pop, 1);
    check({nm, "_rises"},     n_rise, 2);
    check({nm, "_dot_lat"},   rise_t[0] - pop_t[0], 2);
    check({nm, "_dot_len"},   fall_t[0] - rise_t[0], 4);
    check({nm, "_egap_len"},  rise_t[1] - fall_t[0], 4);
    check({nm, "_dash_len"},  fall_t[1] - rise_t[1], 12);
    check({nm, "_done_pos"},  cd_t[0] - fall_t[1], 11);
    check({nm, "_done_cnt"},  n_cd, 1);
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_key",  int'(key_out), 0);
    check("rst_pop",  int'(fifo_pop), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(char_done), 0);
    check("rst_bad",  int'(bad_char), 0);
    rst = 1'b0;

    // 'E': one dot then 12 low cycles, char_done on the 12th
    clear_log();
    push(8'h45);
    repeat (40) tick();
    check("e_pops",     n_pop, 1);
    check("e_rises",    n_rise, 1);
    check("e_lat",      rise_t[0] - pop_t[0], 2);
    check("e_dot_len",  fall_t[0] - rise_t[0], 4);
    check("e_done_pos", cd_t[0] - fall_t[0], 11);
    check("e_done_cnt", n_cd, 1);
    check("e_idle",     int'(busy), 0);

    run_a(8'h41, "ua");
    run_a(8'h61, "la");

    // "E E": each fetch costs IDLE+POP+LOAD, so tone-to-tone = 12 + 3 + 16 + 3
    clear_log();
    push(8'h45); push(8'h20); push(8'h45);
    repeat (90) tick();
    check("ee_pops",     n_pop, 3);
    check("ee_done_cnt", n_cd, 3);
    check("ee_rises",    n_rise, 2);
    check("ee_done0",    cd_t[0] - fall_t[0], 11);
    check("ee_word_len", cd_t[1] - cd_t[0], 19);
    check("ee_restart",  rise_t[1] - cd_t[1], 4);
    check("ee_tone_gap", rise_t[1] - fall_t[0], 34);
    check("ee_bad",      n_bad, 0);

    // '#' rejected, then 'T' (one dash); path pop, LOAD, IDLE, POP, LOAD, ON
    clear_log();
    push(8'h23); push(8'h54);
    repeat (50) tick();
    check("bt_pops",     n_pop, 2);
    check("bt_bad_cnt",  n_bad, 1);
    check("bt_bad_pos",  bad_t[0] - pop_t[0], 2);
    check("bt_rises",    n_rise, 1);
    check("bt_t_lat",    rise_t[0] - pop_t[0], 5);
    check("bt_dash_len", fall_t[0] - rise_t[0], 12);
    check("bt_done_cnt", n_cd, 1);

    // Reset in the 6th cycle of a dash drops the key immediately
    clear_log();
    push(8'h54);
    wait_rise("rd", 20);
    repeat (5) tick();
    check("rd_key_before", int'(key_out), 1);
    rst = 1'b1;
    #1;
    check("rd_key_async",  int'(key_out), 0);
    check("rd_busy_async", int'(busy), 0);
    repeat (2) tick();
    rst = 1'b0;
    clear_log();
    repeat (20) tick();
    check("rd_pops_after", n_pop, 0);
    check("rd_busy_after", int'(busy), 0);
    check("rd_rises",      n_rise, 0);

    // enable low blocks fetching; restoring it drains the pending 'E'
    clear_log();
    enable = 1'b0;
    push(8'h45);
    repeat (20) tick();
    check("en_pops_off", n_pop, 0);
    check("en_busy_off", int'(busy), 0);
    enable = 1'b1;
    repeat (40) tick();
    check("en_pops_on",  n_pop, 1);
    check("en_rises_on", n_rise, 1);

    // Drop enable in the first dash of '0': all five dashes go out, 'E' stays queued
    clear_log();
    push(8'h30); push(8'h45);
    wait_rise("z", 20);
    enable = 1'b0;
    repeat (150) tick();
    check("z_pops",     n_pop, 1);
    check("z_rises",    n_rise, 5);
    check("z_done_cnt", n_cd, 1);
    for (int i = 0; i < 5; i++) check($sformatf("z_dash%0d_len", i), fall_t[i] - rise_t[i], 12);
    for (int i = 1; i < 5; i++) check($sformatf("z_gap%0d_len", i), rise_t[i] - fall_t[i-1], 4);
    check("z_left",     int'(wr_ptr - rd_ptr), 1);
    check("z_busy",     int'(busy), 0);
    check("underflow",  int'(underflow), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
